// File: rtl/tt_um_semis_uabc_diff_tx.sv
// Differential UART-style byte transmitter: START, 8 data bits LSB first, even parity, STOP,
// with a selectable bit period and a TXP/TXN pair that idles at mark or floats to common-mode.
module tt_um_semis_uabc_diff_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  data_q;
    logic [1:0]  div_sel_q;
    logic [5:0]  div_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic        ret_q;
    logic        send_meta_q;
    logic        send_sync_q;
    logic        send_prev_q;
    logic        en_meta_q;
    logic        en_sync_q;
    logic        txp_q;
    logic        txn_q;
    logic        busy_q;
    logic        done_q;

    logic        send_edge_s;
    logic        bit_end_s;
    logic        line_bit_s;
    logic        unused_s;

    // Last divider count of a bit period for each DIVSEL code.
    function automatic logic [5:0] div_limit(input logic [1:0] sel);
        logic [5:0] lim;
        case (sel)
            2'b00:   lim = 6'd0;
            2'b01:   lim = 6'd3;
            2'b10:   lim = 6'd15;
            2'b11:   lim = 6'd63;
            default: lim = 6'd0;
        endcase
        return lim;
    endfunction

    function automatic logic even_parity8(input logic [7:0] d);
        return ^d;
    endfunction

    assign unused_s = &{1'b0, ena, uio_in[7:4]};

    // Two-flop synchronizers for SEND and TX_EN plus the SEND history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_meta_q <= 1'b0;
            send_sync_q <= 1'b0;
            send_prev_q <= 1'b0;
            en_meta_q   <= 1'b0;
            en_sync_q   <= 1'b0;
        end else begin
            send_meta_q <= uio_in[0];
            send_sync_q <= send_meta_q;
            send_prev_q <= send_sync_q;
            en_meta_q   <= uio_in[1];
            en_sync_q   <= en_meta_q;
        end
    end

    // Edge detect, bit-boundary detect and the line level the current state calls for.
    always_comb begin
        send_edge_s = send_sync_q & ~send_prev_q;
        bit_end_s   = (div_cnt_q == div_limit(div_sel_q));
        line_bit_s  = 1'b1;
        case (state_q)
            IDLE:    line_bit_s = 1'b1;
            START:   line_bit_s = 1'b0;
            DATA:    line_bit_s = data_q[bit_cnt_q];
            PARITY:  line_bit_s = even_parity8(data_q);
            STOP:    line_bit_s = 1'b1;
            default: line_bit_s = 1'b1;
        endcase
    end

    // Frame sequencer and registered line/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= 8'd0;
            div_sel_q <= 2'd0;
            div_cnt_q <= 6'd0;
            bit_cnt_q <= 3'd0;
            ret_q     <= 1'b0;
            txp_q     <= 1'b0;
            txn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Outputs follow the state held during the previous cycle; disable wins immediately.
            txp_q  <= en_sync_q & line_bit_s;
            txn_q  <= en_sync_q & ~line_bit_s;
            busy_q <= en_sync_q & (state_q != IDLE);
            done_q <= ret_q;
            ret_q  <= 1'b0;

            if ((state_q != IDLE) && !en_sync_q) begin
                state_q   <= IDLE;
                div_cnt_q <= 6'd0;
                bit_cnt_q <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // ret_q marks the cycle right after STOP, where a new edge is dropped.
                        if (en_sync_q && send_edge_s && !ret_q) begin
                            data_q    <= ui_in;
                            div_sel_q <= uio_in[3:2];
                            div_cnt_q <= 6'd0;
                            bit_cnt_q <= 3'd0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    START: begin
                        if (bit_end_s) begin
                            div_cnt_q <= 6'd0;
                            state_q   <= DATA;
                        end else begin
                            div_cnt_q <= div_cnt_q + 6'd1;
                        end
                    end
                    DATA: begin
                        if (bit_end_s) begin
                            div_cnt_q <= 6'd0;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= 3'd0;
                                state_q   <= PARITY;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 6'd1;
                        end
                    end
                    PARITY: begin
                        if (bit_end_s) begin
                            div_cnt_q <= 6'd0;
                            state_q   <= STOP;
                        end else begin
                            div_cnt_q <= div_cnt_q + 6'd1;
                        end
                    end
                    STOP: begin
                        if (bit_end_s) begin
                            div_cnt_q <= 6'd0;
                            ret_q     <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            div_cnt_q <= div_cnt_q + 6'd1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        div_cnt_q <= 6'd0;
                        bit_cnt_q <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign uo_out  = {4'b0000, done_q, busy_q, txn_q, txp_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_semis_uabc_diff_tx.sv
// Bench for the differential transmitter: frame-level reference model compared every cycle,
// directed frames pinned with hand-computed values, then randomized traffic.
module tb_tt_um_semis_uabc_diff_tx;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is an 11-entry bit array walked at one entry per period.
    logic        m_s1, m_s2, m_prev, m_e1, m_e2;
    int          m_pos;
    int          m_cyc;
    int          m_period;
    logic [10:0] m_frame;
    logic        m_ret;
    logic        m_txp, m_txn, m_busy, m_done;

    // Recorders of DUT behaviour for the directed literal checks.
    int   busy_cnt;
    int   done_cnt;
    logic txp_rec[$];

    tt_um_semis_uabc_diff_tx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_e1 = 1'b0; m_e2 = 1'b0;
        m_pos = -1; m_cyc = 0; m_period = 1; m_frame = 11'd0; m_ret = 1'b0;
        m_txp = 1'b0; m_txn = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        logic bitv;
        logic edge_seen;
        logic ret_new;
        bitv = (m_pos < 0) ? 1'b1 : m_frame[m_pos];
        m_txp  = m_e2 & bitv;
        m_txn  = m_e2 & ~bitv;
        m_busy = m_e2 && (m_pos >= 0);
        m_done = m_ret;
        edge_seen = m_s2 & ~m_prev;
        ret_new = 1'b0;
        if (m_pos >= 0) begin
            if (!m_e2) begin
                m_pos = -1;
            end else if (m_cyc == m_period - 1) begin
                m_cyc = 0;
                m_pos = m_pos + 1;
                if (m_pos == 11) begin
                    m_pos = -1;
                    ret_new = 1'b1;
                end
            end else begin
                m_cyc = m_cyc + 1;
            end
        end else if (m_e2 && edge_seen && !m_ret) begin
            m_frame = {1'b1, ^ui_in, ui_in, 1'b0};
            m_period = 1 << (2 * int'(uio_in[3:2]));
            m_pos = 0;
            m_cyc = 0;
        end
        m_ret = ret_new;
        m_prev = m_s2; m_s2 = m_s1; m_s1 = uio_in[0];
        m_e2 = m_e1;   m_e1 = uio_in[1];
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus the standing invariants.
    task automatic check_outputs();
        logic [7:0] exp;
        exp = {4'b0000, m_done, m_busy, m_txn, m_txp};
        total++;
        if (uo_out !== exp) begin
            bad++;
            $display("FAIL uo_out: got %02h expected %02h at %0t", uo_out, exp, $time);
        end
        total++;
        if (uo_out[0] === 1'b1 && uo_out[1] === 1'b1) begin
            bad++;
            $display("FAIL txp_txn_both_high: got uo_out=%02h at %0t", uo_out, $time);
        end
        total++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL uio_tied: got out=%02h oe=%02h expected 00/00 at %0t", uio_out, uio_oe, $time);
        end
        if (uo_out[2] === 1'b1) begin
            busy_cnt++;
            txp_rec.push_back(uo_out[0]);
        end
        if (uo_out[3] === 1'b1) done_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_rec();
        busy_cnt = 0;
        done_cnt = 0;
        txp_rec.delete();
    endtask

    // Pulse SEND for one cycle, then wait (bounded) for BUSY; returns cycles to BUSY.
    task automatic start_frame(input logic [7:0] data, input logic [1:0] sel, output int lat);
        ui_in  = data;
        uio_in = {4'b0000, sel, 1'b1, 1'b1};
        tick();
        uio_in[0] = 1'b0;
        lat = 1;
        while (uo_out[2] !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        if (uo_out[2] !== 1'b1) check_lit("busy_timeout", 0, 1);
    endtask

    int lat;
    int a5_exp[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        clear_rec();
        #1;
        check_lit("reset_uo_out", int'(uo_out), 0);
        ticks(3);
        rst_n = 1'b1;
        ticks(4);
        check_lit("disabled_after_reset", int'(uo_out), 0);
        uio_in[1] = 1'b1;
        ticks(4);
        check_lit("mark_when_enabled", int'(uo_out), 1);

        // Divider 1, 0xA5.
        clear_rec();
        start_frame(8'hA5, 2'b00, lat);
        check_lit("start_latency", lat, 4);
        check_lit("start_txp", int'(uo_out[0]), 0);
        ticks(16);
        check_lit("a5_busy_cycles", busy_cnt, 11);
        check_lit("a5_done_pulses", done_cnt, 1);
        check_lit("a5_bits", txp_rec.size(), 11);
        for (int i = 0; i < 11 && i < txp_rec.size(); i++)
            check_lit($sformatf("a5_bit%0d", i), int'(txp_rec[i]), a5_exp[i]);

        // Divider 4, 0x01, with DIVSEL pins changed mid-frame.
        clear_rec();
        start_frame(8'h01, 2'b01, lat);
        uio_in[3:2] = 2'b11;
        ticks(50);
        check_lit("d4_busy_cycles", busy_cnt, 44);
        check_lit("d4_done_pulses", done_cnt, 1);
        if (txp_rec.size() == 44) begin
            check_lit("d4_data0", int'(txp_rec[4]) + int'(txp_rec[7]), 2);
            check_lit("d4_data1", int'(txp_rec[8]), 0);
            check_lit("d4_parity", int'(txp_rec[36]) + int'(txp_rec[39]), 2);
        end

        // Abort by clearing TX_EN during data bit 3 at divider 16.
        clear_rec();
        start_frame(8'hFF, 2'b10, lat);
        ticks(70);
        uio_in[1] = 1'b0;
        ticks(3);
        check_lit("abort_uo_out", int'(uo_out[3:0]), 0);
        ticks(40);
        check_lit("abort_no_done", done_cnt, 0);
        uio_in[1] = 1'b1;
        ticks(4);

        // Second SEND during PARITY is dropped.
        clear_rec();
        start_frame(8'h5A, 2'b01, lat);
        ticks(36);
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ticks(30);
        check_lit("collide_busy_cycles", busy_cnt, 44);
        check_lit("collide_done_pulses", done_cnt, 1);

        // Reset during STOP, then a normal frame.
        start_frame(8'hC3, 2'b01, lat);
        ticks(41);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_lit("reset_mid_stop", int'(uo_out), 0);
        check_outputs();
        ticks(2);
        rst_n = 1'b1;
        ticks(4);
        clear_rec();
        start_frame(8'h3C, 2'b00, lat);
        ticks(16);
        check_lit("post_reset_busy", busy_cnt, 11);
        check_lit("post_reset_done", done_cnt, 1);

        // Randomized traffic checked only by the model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ui_in = 8'($urandom);
            uio_in[7:4] = 4'($urandom);
            uio_in[3:2] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            if (r < 10) uio_in[0] = ~uio_in[0];
            if (r == 99) uio_in[1] = ~uio_in[1];
            if (r == 98) uio_in[1] = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
